path_metric_unit: RTL
=====================

PATH_METRIC_UNIT -- requirements
Module: path_metric_unit

Interface
REQ-001 SHALL have parameter PM_W, default 8: path metric width in bits, legal 6..12.
REQ-002 SHALL have parameter INIT_PM, default 2**(PM_W-2): start metric for every non-zero state at frame start.
REQ-003 SHALL have port clk  input  1: single rising-edge clock.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1: branch-metric set presented.
REQ-006 SHALL have port in_ready  output  1: unit accepts the set this cycle.
REQ-007 SHALL have port frame_start  input  1: qualified by in_valid; this step is trellis step 0.
REQ-008 SHALL have port bm0  input  8x2: per next-state n, 2-bit cost of branch from predecessor {n[1:0],0} (bmc path_0 output).
REQ-009 SHALL have port bm1  input  8x2: per next-state n, 2-bit cost of branch from predecessor {n[1:0],1} (bmc path_1 output).
REQ-010 SHALL have port out_valid  output  1: decision word valid.
REQ-011 SHALL have port out_ready  input  1: downstream traceback accepts.
REQ-012 SHALL have port dec  output  8: survivor bit per state; 1 = predecessor {n[1:0],1} chosen.
REQ-013 SHALL have port best_state  output  3: index of smallest updated metric.
REQ-014 SHALL have port best_pm  output  PM_W: value of that metric.
REQ-015 SHALL have port step_cnt  output  16: steps accepted since last frame_start, wraps 0xFFFF->0.

Function
REQ-016 SHALL accept on fire = in_valid & in_ready; in_ready = !out_valid | out_ready (one-deep output register, no combinational valid->ready path).
REQ-017 SHALL, on fire, compute for each n: c0 = pm[{n[1:0],0}] + bm0[n], c1 = pm[{n[1:0],1}] + bm1[n] at PM_W+1 bits; new pm[n] = min(c0,c1); dec[n] = (c1 < c0); tie selects c0, dec=0.
REQ-018 SHALL, when frame_start fires, use prior metrics {0, INIT_PM x7} (state 0 zero) instead of stored pm.
REQ-019 SHALL register pm, dec, best_state, best_pm and set out_valid the cycle after fire (latency 1).
REQ-020 SHALL pick best_state as lowest index among equal minima.
REQ-021 SHALL hold dec/best_* and out_valid stable while out_valid & !out_ready.
REQ-022 SHALL, on fire with out_valid & out_ready in same cycle, replace output with new result, out_valid stays 1 (full throughput).
REQ-023 SHALL set step_cnt to 1 on fire with frame_start, else increment on every fire.
REQ-024 SHALL ignore bm0/bm1/frame_start when in_valid=0.

Reset
REQ-025 SHALL on rst_n=0 asynchronously clear out_valid, dec, best_state, best_pm, step_cnt to 0 and set pm to {0, INIT_PM x7}.
REQ-026 SHALL drop any in-flight result on reset mid-frame; first post-reset step behaves as frame_start even if frame_start=0.

Configuration
REQ-027 SHALL with PM_NORM_EN defined: when every new pm[n] >= 2**(PM_W-1), subtract 2**(PM_W-1) from all eight in the same update (relative order preserved, no saturation).
REQ-028 SHALL without PM_NORM_EN: saturate each new pm[n] at 2**PM_W-1; no normalisation logic present.

Structure
REQ-029 SHALL take NSTATE=8, state index typedef, bm pair typedef and predecessor function from shared package viterbi_pkg.
REQ-030 SHALL instantiate sub-module acs_cell once per state (add, compare, select, decision bit); normalisation/saturation and best-state search in the top.

Verification
REQ-031 Frame_start, all bm0=0, bm1=2 -> out 1 cycle later: pm={0,INIT x3 ...}, dec=0x00, best_state=0, best_pm=0, step_cnt=1.
REQ-032 Equal c0=c1 on every state -> dec=0x00 (tie rule), best_state lowest index.
REQ-033 out_ready held 0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen; release -> next set accepted, no loss or duplicate.
REQ-034 PM_W=6, 40 steps of bm=2 everywhere: with PM_NORM_EN all pm stay <64 and differences match reference model; without, pm saturate at 63.
REQ-035 Encoded stream 1011 through bmc instances, no errors -> best_state sequence 4,2,5,6 (n={bit,s[2:1]}), best_pm=0 each step.
REQ-036 rst_n pulsed low mid-frame while out_valid=1 -> out_valid=0 immediately, next step restarts at step_cnt=1 with initial metrics.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the 8-state Viterbi datapath: state index, branch-metric
// types and the predecessor mapping n -> {n[1:0], b}.
package viterbi_pkg;

   localparam int unsigned NSTATE = 8;
   localparam int unsigned SW     = 3;

   typedef logic [SW-1:0] state_t;
   typedef logic [1:0]    bm_t;

   typedef struct packed {
      bm_t bm0;
      bm_t bm1;
   } bm_pair_t;

   function automatic state_t pred(input state_t n, input logic b);
      return {n[1:0], b};
   endfunction

endpackage

// File: rtl/acs_cell.sv
// Add-compare-select for one trellis state; a tie keeps the even predecessor (dec = 0).
module acs_cell
   import viterbi_pkg::*;
#(
   parameter int unsigned PM_W = 8
) (
   input  logic [PM_W-1:0] i_pm0,
   input  logic [PM_W-1:0] i_pm1,
   input  bm_pair_t        i_bm,
   output logic [PM_W:0]   o_sum,
   output logic            o_dec
);

   logic [PM_W:0] w_c0;
   logic [PM_W:0] w_c1;

   assign w_c0  = {1'b0, i_pm0} + {{(PM_W-1){1'b0}}, i_bm.bm0};
   assign w_c1  = {1'b0, i_pm1} + {{(PM_W-1){1'b0}}, i_bm.bm1};
   assign o_dec = (w_c1 < w_c0);
   assign o_sum = o_dec ? w_c1 : w_c0;

endmodule

// File: rtl/path_metric_unit.sv
// Viterbi path-metric update with a one-deep output register and best-state search.
// Define PM_NORM_EN to normalise metrics by 2**(PM_W-1); otherwise metrics saturate.
module path_metric_unit
   import viterbi_pkg::*;
#(
   parameter int unsigned PM_W    = 8,
   parameter int unsigned INIT_PM = 2 ** (PM_W - 2)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              frame_start,
   input  bm_t [NSTATE-1:0]  bm0,
   input  bm_t [NSTATE-1:0]  bm1,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [NSTATE-1:0] dec,
   output state_t            best_state,
   output logic [PM_W-1:0]   best_pm,
   output logic [15:0]       step_cnt
);

   localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);

   logic              r_out_valid;
   logic [PM_W-1:0]   r_pm [NSTATE];
   logic [NSTATE-1:0] r_dec;
   state_t            r_best_state;
   logic [PM_W-1:0]   r_best_pm;
   logic [15:0]       r_step_cnt;

   logic              w_fire;
   logic [PM_W-1:0]   w_prior [NSTATE];
   logic [PM_W:0]     w_sum [NSTATE];
   logic [PM_W-1:0]   w_new [NSTATE];
   logic [NSTATE-1:0] w_dec;
   state_t            w_best_state;
   logic [PM_W-1:0]   w_best_pm;

   // Ready depends only on the output register, never on in_valid.
   assign in_ready = !r_out_valid | out_ready;
   assign w_fire   = in_valid & in_ready;

   always_comb begin
      for (int n = 0; n < NSTATE; n++) begin
         w_prior[n] = r_pm[n];
         if (frame_start) begin
            w_prior[n] = (n == 0) ? '0 : INIT_V;
         end
      end
   end

   for (genvar g = 0; g < NSTATE; g++) begin : g_acs
      bm_pair_t w_bm;
      assign w_bm = '{bm0: bm0[g], bm1: bm1[g]};
      acs_cell #(
         .PM_W (PM_W)
      ) u_acs (
         .i_pm0 (w_prior[pred(state_t'(g), 1'b0)]),
         .i_pm1 (w_prior[pred(state_t'(g), 1'b1)]),
         .i_bm  (w_bm),
         .o_sum (w_sum[g]),
         .o_dec (w_dec[g])
      );
   end

`ifdef PM_NORM_EN
   localparam logic [PM_W:0] HALF = (PM_W + 1)'(2 ** (PM_W - 1));
   logic w_all_high;

   always_comb begin
      w_all_high = 1'b1;
      for (int n = 0; n < NSTATE; n++) begin
         if (w_sum[n] < HALF) w_all_high = 1'b0;
      end
      for (int n = 0; n < NSTATE; n++) begin
         w_new[n] = w_all_high ? PM_W'(w_sum[n] - HALF) : w_sum[n][PM_W-1:0];
      end
   end
`else
   always_comb begin
      for (int n = 0; n < NSTATE; n++) begin
         w_new[n] = w_sum[n][PM_W] ? {PM_W{1'b1}} : w_sum[n][PM_W-1:0];
      end
   end
`endif

   // Strict less-than keeps the lowest index among equal minima.
   always_comb begin
      w_best_state = '0;
      w_best_pm    = w_new[0];
      for (int n = 1; n < NSTATE; n++) begin
         if (w_new[n] < w_best_pm) begin
            w_best_state = state_t'(n);
            w_best_pm    = w_new[n];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_dec        <= '0;
         r_best_state <= '0;
         r_best_pm    <= '0;
         r_step_cnt   <= '0;
         for (int n = 0; n < NSTATE; n++) begin
            r_pm[n] <= (n == 0) ? '0 : INIT_V;
         end
      end else if (w_fire) begin
         r_out_valid  <= 1'b1;
         r_dec        <= w_dec;
         r_best_state <= w_best_state;
         r_best_pm    <= w_best_pm;
         r_step_cnt   <= frame_start ? 16'd1 : r_step_cnt + 16'd1;
         for (int n = 0; n < NSTATE; n++) begin
            r_pm[n] <= w_new[n];
         end
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid  = r_out_valid;
   assign dec        = r_dec;
   assign best_state = r_best_state;
   assign best_pm    = r_best_pm;
   assign step_cnt   = r_step_cnt;

endmodule
